pc_fetch_unit: RTL and testbench

- Program-counter and instruction-fetch register stage of the multicycle CPU. It sits directly downstream of the control FSM and consumes its PC_WE, PCSrc, IR_WE, Branch and JAL outputs.
- Holds PC, IR and the latched next-PC (NPC), and computes jump and branch targets.
- Supplies the instruction word back to the FSM and the link address to the register-file write mux.
- Also keeps a retired-instruction counter and a sticky misalignment flag.

---
 rtl/pc_fetch_unit.sv | 117 +++++++++++
 tb/tb_pc_fetch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Program-counter / instruction-fetch register stage of the multicycle CPU.
// It holds PC, IR and the next-PC latched at fetch (NPC), and forms the jump,
// jump-register and branch targets. It also keeps a retired-instruction
// counter and a sticky misaligned-PC flag. All sequencing comes from the
// external control FSM; this block has no state machine of its own.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   PC_WE, IR_WE    write enables from the FSM
//   PCSrc[1:0]      next-PC select: 00 seq, 01 jump, 10 jr, 11 branch
//   Branch[3:0]     [0] take on alu_zero, [1] take on !alu_zero, [3:2] unused
//   JAL             jump-and-link indicator
//   alu_zero        ALU zero flag
//   rs_value        JR target (register A)
//   mem_rdata       instruction memory read data
//   pc              current PC / instruction memory address
//   instruction     IR contents
//   npc             PC+4 latched at fetch
//   link_addr       npc when JAL, else 0
//   link_we         JAL & PC_WE & (PCSrc==01)
//   branch_taken    one-cycle pulse following a taken branch write
//   instr_count     retired-instruction counter (wraps)
//   pc_misaligned   sticky: PC was ever written with [1:0] != 0
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PC_WE,
    input  logic [1:0]         PCSrc,
    input  logic               IR_WE,
    input  logic [3:0]         Branch,
    input  logic               JAL,
    input  logic               alu_zero,
    input  logic [31:0]        rs_value,
    input  logic [31:0]        mem_rdata,
    output logic [31:0]        pc,
    output logic [31:0]        instruction,
    output logic [31:0]        npc,
    output logic [31:0]        link_addr,
    output logic               link_we,
    output logic               branch_taken,
    output logic [COUNT_W-1:0] instr_count,
    output logic               pc_misaligned
);

    typedef enum logic [1:0] {
        SRC_SEQ = 2'b00,
        SRC_J   = 2'b01,
        SRC_JR  = 2'b10,
        SRC_BR  = 2'b11
    } pc_src_e;

    logic [31:0] pc_plus4;
    logic [31:0] jump_tgt;
    logic [31:0] br_tgt;
    logic [31:0] pc_next;
    logic        br_cond;
    logic        pc_wr;
    logic        br_wr;

    assign pc_plus4 = pc + 32'd4;
    assign jump_tgt = {npc[31:28], instruction[25:0], 2'b00};
    assign br_tgt   = npc + {{14{instruction[15]}}, instruction[15:0], 2'b00};

    // Branch[1:0]==00 means an unconditional branch; ==11 is always taken
    // because the two terms cover both values of alu_zero.
    always_comb begin
        br_cond = 1'b1;
        if (Branch[1:0] != 2'b00)
            br_cond = (Branch[0] & alu_zero) | (Branch[1] & ~alu_zero);
    end

    always_comb begin
        pc_next = pc_plus4;
        unique case (pc_src_e'(PCSrc))
            SRC_SEQ: pc_next = pc_plus4;
            SRC_J:   pc_next = jump_tgt;
            SRC_JR:  pc_next = rs_value;
            SRC_BR:  pc_next = br_tgt;
        endcase
    end

    assign br_wr = PC_WE & (PCSrc == SRC_BR) & br_cond;
    assign pc_wr = PC_WE & ((PCSrc != SRC_BR) | br_cond);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc            <= RESET_PC;
            instruction   <= 32'h0;
            npc           <= RESET_PC + 32'd4;
            branch_taken  <= 1'b0;
            instr_count   <= '0;
            pc_misaligned <= 1'b0;
        end else begin
            // All right-hand sides use pre-edge values, so a combined
            // fetch + PC write sees the old pc, instruction and npc.
            if (IR_WE) begin
                instruction <= mem_rdata;
                npc         <= pc_plus4;
                instr_count <= instr_count + 1'b1;
            end
            if (pc_wr) begin
                pc <= pc_next;
                if (pc_next[1:0] != 2'b00)
                    pc_misaligned <= 1'b1;
            end
            branch_taken <= br_wr;
        end
    end

    assign link_addr = JAL ? npc : 32'h0;
    assign link_we   = JAL & PC_WE & (PCSrc == SRC_J);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed-vector bench for pc_fetch_unit. The counter is instantiated
// 8 bits wide so the wrap can be reached by real fetches.
module tb_pc_fetch_unit;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          PC_WE;
    logic [1:0]    PCSrc;
    logic          IR_WE;
    logic [3:0]    Branch;
    logic          JAL;
    logic          alu_zero;
    logic [31:0]   rs_value;
    logic [31:0]   mem_rdata;
    logic [31:0]   pc;
    logic [31:0]   instruction;
    logic [31:0]   npc;
    logic [31:0]   link_addr;
    logic          link_we;
    logic          branch_taken;
    logic [CW-1:0] instr_count;
    logic          pc_misaligned;

    int n_vec = 0;
    int n_err = 0;

    pc_fetch_unit #(.RESET_PC(32'h0), .COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .PC_WE(PC_WE), .PCSrc(PCSrc), .IR_WE(IR_WE),
        .Branch(Branch), .JAL(JAL), .alu_zero(alu_zero), .rs_value(rs_value),
        .mem_rdata(mem_rdata), .pc(pc), .instruction(instruction), .npc(npc),
        .link_addr(link_addr), .link_we(link_we), .branch_taken(branch_taken),
        .instr_count(instr_count), .pc_misaligned(pc_misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of control, then sample 1 ns after the edge.
    task automatic step(input logic pwe, input logic [1:0] src, input logic iwe,
                        input logic [3:0] br, input logic jal, input logic z,
                        input logic [31:0] rs, input logic [31:0] rd);
        PC_WE = pwe; PCSrc = src; IR_WE = iwe; Branch = br; JAL = jal;
        alu_zero = z; rs_value = rs; mem_rdata = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic jr(input logic [31:0] tgt);
        step(1'b1, 2'b10, 1'b0, 4'b0000, 1'b0, 1'b0, tgt, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] word);
        step(1'b0, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, word);
    endtask

    initial begin
        reset = 1'b1;
        PC_WE = 0; PCSrc = 0; IR_WE = 0; Branch = 0; JAL = 0;
        alu_zero = 0; rs_value = 0; mem_rdata = 0;
        #3;
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", instruction, 32'h0);
        chk("rst_npc", npc, 32'h4);
        chk("rst_bt", {31'b0, branch_taken}, 32'h0);
        chk("rst_cnt", {24'b0, instr_count}, 32'h0);
        chk("rst_mis", {31'b0, pc_misaligned}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Combined fetch + sequential PC write
        step(1'b1, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h2008_0005);
        chk("seq_pc", pc, 32'h4);
        chk("seq_ir", instruction, 32'h2008_0005);
        chk("seq_npc", npc, 32'h4);
        chk("seq_cnt", {24'b0, instr_count}, 32'h1);

        // J at pc=0x10, target field 0x10 -> 0x40
        jr(32'h10);
        chk("jr10_pc", pc, 32'h10);
        fetch(32'h0800_0010);
        chk("j_npc", npc, 32'h14);
        step(1'b1, 2'b01, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("j_pc", pc, 32'h40);
        chk("j_bt", {31'b0, branch_taken}, 32'h0);

        // BEQ imm=-2 at pc=0x1C (npc=0x20) -> target 0x18
        jr(32'h1C);
        fetch(32'h1000_FFFE);
        chk("beq_npc", npc, 32'h20);
        chk("beq_cnt", {24'b0, instr_count}, 32'h3);
        step(1'b1, 2'b11, 1'b0, 4'b0001, 1'b0, 1'b1, 32'h0, 32'h0);
        chk("beq_t_pc", pc, 32'h18);
        chk("beq_t_bt", {31'b0, branch_taken}, 32'h1);
        idle();
        chk("beq_bt_pulse", {31'b0, branch_taken}, 32'h0);
        chk("beq_hold_pc", pc, 32'h18);
        jr(32'h1C);
        step(1'b1, 2'b11, 1'b0, 4'b0001, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("beq_nt_pc", pc, 32'h1C);
        chk("beq_nt_bt", {31'b0, branch_taken}, 32'h0);
        // BNE with zero set: not taken
        step(1'b1, 2'b11, 1'b0, 4'b0010, 1'b0, 1'b1, 32'h0, 32'h0);
        chk("bne_nt_pc", pc, 32'h1C);
        // Branch[1:0]=00 is unconditional
        step(1'b1, 2'b11, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("buncond_pc", pc, 32'h18);
        chk("buncond_bt", {31'b0, branch_taken}, 32'h1);
        // Upper Branch bits ignored: 1101 behaves as BEQ, zero clear -> not taken
        jr(32'h1C);
        step(1'b1, 2'b11, 1'b0, 4'b1101, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("bhi_pc", pc, 32'h1C);
        chk("bhi_bt", {31'b0, branch_taken}, 32'h0);
        // Branch[1:0]=11 always taken
        step(1'b1, 2'b11, 1'b0, 4'b0011, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("balw_pc", pc, 32'h18);
        chk("balw_bt", {31'b0, branch_taken}, 32'h1);
        // Branch with PC_WE low does nothing
        step(1'b0, 2'b11, 1'b0, 4'b0011, 1'b0, 1'b1, 32'h0, 32'h0);
        chk("bnowe_pc", pc, 32'h18);
        chk("bnowe_bt", {31'b0, branch_taken}, 32'h0);

        // Misaligned JR sets the sticky flag
        chk("mis_before", {31'b0, pc_misaligned}, 32'h0);
        jr(32'h0000_0102);
        chk("mis_pc", pc, 32'h102);
        chk("mis_set", {31'b0, pc_misaligned}, 32'h1);
        jr(32'h200);
        step(1'b1, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("mis_pc2", pc, 32'h204);
        chk("mis_sticky", {31'b0, pc_misaligned}, 32'h1);

        // JAL at pc=0x8 (npc=0xC)
        jr(32'h8);
        fetch(32'h0C00_0010);
        chk("jal_npc", npc, 32'hC);
        chk("jal_cnt", {24'b0, instr_count}, 32'h4);
        PC_WE = 1'b0; PCSrc = 2'b01; JAL = 1'b1;
        #1;
        chk("jal_nowe_we", {31'b0, link_we}, 32'h0);
        chk("jal_nowe_la", link_addr, 32'hC);
        PC_WE = 1'b1;
        #1;
        chk("jal_la", link_addr, 32'hC);
        chk("jal_we", {31'b0, link_we}, 32'h1);
        PCSrc = 2'b10;
        #1;
        chk("jal_jr_we", {31'b0, link_we}, 32'h0);
        PCSrc = 2'b01; JAL = 1'b0;
        #1;
        chk("nojal_la", link_addr, 32'h0);
        JAL = 1'b1;
        // Take the JAL so branch_taken/pc are non-reset, then make bt=1
        @(posedge clk); #1;
        chk("jal_pc", pc, 32'h40);
        step(1'b1, 2'b11, 1'b0, 4'b0011, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("pre_rst_bt", {31'b0, branch_taken}, 32'h1);
        // Asynchronous reset mid-cycle
        #2;
        reset = 1'b1;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_ir", instruction, 32'h0);
        chk("arst_npc", npc, 32'h4);
        chk("arst_bt", {31'b0, branch_taken}, 32'h0);
        chk("arst_cnt", {24'b0, instr_count}, 32'h0);
        chk("arst_mis", {31'b0, pc_misaligned}, 32'h0);
        chk("arst_la", link_addr, 32'h4);
        @(negedge clk);
        reset = 1'b0;
        JAL = 1'b0;

        // Counter wrap at 2^CW
        for (int i = 0; i < (1 << CW) - 1; i++) fetch(32'h0000_0000);
        chk("cnt_max", {24'b0, instr_count}, 32'hFF);
        fetch(32'h0000_0000);
        chk("cnt_wrap", {24'b0, instr_count}, 32'h0);

        // PC and NPC wrap at the top of the address space
        jr(32'hFFFF_FFFC);
        chk("top_pc", pc, 32'hFFFF_FFFC);
        step(1'b1, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h1234_5678);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_npc", npc, 32'h0);
        chk("wrap_ir", instruction, 32'h1234_5678);
        chk("wrap_mis", {31'b0, pc_misaligned}, 32'h0);

        // Hold when no enables
        idle();
        idle();
        chk("hold_pc", pc, 32'h0);
        chk("hold_cnt", {24'b0, instr_count}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
